// File: rtl/transpose_pkg.sv
`default_nettype none
// ============================================================================
// Module   : transpose_pkg
// Brief    : Shared types and state encodings for the matrix transposer and
//            its downstream row streamer.
// Revision : 1.0 - initial release
// ============================================================================
package transpose_pkg;

   localparam int IL_DEF = 8;
   localparam int FL_DEF = 12;

   typedef logic signed [IL_DEF+FL_DEF-1:0] elem_t;

   // Transposer state encodings, shared with the upstream transposer.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } stream_state_e;

   // Width of an index over n items, never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : transpose_pkg
`default_nettype wire

// File: rtl/transpose_row_sum.sv
`default_nettype none
// ============================================================================
// Module   : transpose_row_sum
// Brief    : Combinational exact sum of N signed elements, widened by
//            clog2(N) bits so no input pattern can overflow.
// Revision : 1.0 - initial release
// ============================================================================
module transpose_row_sum #(
   parameter int N     = 4,
   parameter int W     = 20,
   parameter int SUM_W = W + $clog2(N)
) (
   input  logic signed [W-1:0]     din [N-1:0],
   output logic signed [SUM_W-1:0] sum
);

   always_comb begin
      sum = '0;
      for (int i = 0; i < N; i++) begin
         // Size cast of a signed operand sign-extends before the add.
         sum = sum + SUM_W'(din[i]);
      end
   end

endmodule : transpose_row_sum
`default_nettype wire

// File: rtl/transpose_row_streamer.sv
`default_nettype none
// ============================================================================
// Module   : transpose_row_streamer
// Brief    : Captures a finished COL x ROW transposed matrix in one cycle and
//            streams it one row per valid/ready beat.
// Config   : TRANSPOSE_ROW_STREAMER_ROW_SUM_EN adds the row_sum output.
// Revision : 1.0 - initial release
// ============================================================================
module transpose_row_streamer
   import transpose_pkg::*;
#(
   parameter int IL  = 8,
   parameter int FL  = 12,
   parameter int ROW = 4,
   parameter int COL = 4,
   localparam int W  = IL + FL,
   localparam int IW = idx_width(COL)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          src_state,
   input  logic signed [W-1:0] src_mat [COL-1:0][ROW-1:0],
   output logic                output_taken,
   output logic                row_valid,
   input  logic                row_ready,
   output logic signed [W-1:0] row_data [ROW-1:0],
   output logic [IW-1:0]       row_idx,
   output logic                row_last,
   output logic                busy
`ifdef TRANSPOSE_ROW_STREAMER_ROW_SUM_EN
   ,
   output logic signed [W+$clog2(ROW)-1:0] row_sum
`endif
);

   localparam logic [IW-1:0] LAST_IDX = IW'(COL - 1);

   stream_state_e       state_q, state_d;
   logic signed [W-1:0] buf_q [COL-1:0][ROW-1:0];
   logic signed [W-1:0] buf_d [COL-1:0][ROW-1:0];
   logic [IW-1:0]       row_idx_q, row_idx_d;

   logic capture;
   logic handshake;
   logic last_beat;

   // The transposer clears its result on the capture edge, so capture must
   // be decided purely from the current-cycle state.
   assign capture   = (state_q == IDLE) && (src_state == ST_DONE);
   assign handshake = (state_q == STREAM) && row_ready;
   assign last_beat = (row_idx_q == LAST_IDX);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (capture) state_d = STREAM;
         STREAM:  if (handshake && last_beat) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      output_taken = 1'b0;
      row_valid    = 1'b0;
      busy         = 1'b0;
      case (state_q)
         IDLE:    output_taken = capture && reset_n;
         STREAM: begin
            row_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_idx_q <= '0;
         for (int c = 0; c < COL; c++) begin
            for (int r = 0; r < ROW; r++) begin
               buf_q[c][r] <= '0;
            end
         end
      end else begin
         row_idx_q <= row_idx_d;
         buf_q     <= buf_d;
      end
   end

   always_comb begin
      buf_d     = buf_q;
      row_idx_d = row_idx_q;
      if (capture) begin
         buf_d     = src_mat;
         row_idx_d = '0;
      end else if (handshake) begin
         row_idx_d = last_beat ? '0 : row_idx_q + 1'b1;
      end
   end

   assign row_data = buf_q[row_idx_q];
   assign row_idx  = row_idx_q;
   assign row_last = row_valid && last_beat;

`ifdef TRANSPOSE_ROW_STREAMER_ROW_SUM_EN
   transpose_row_sum #(
      .N     (ROW),
      .W     (W),
      .SUM_W (W + $clog2(ROW))
   ) u_row_sum (
      .din (buf_q[row_idx_q]),
      .sum (row_sum)
   );
`endif

endmodule : transpose_row_streamer
`default_nettype wire
